// File: rtl/bell_pkg.sv
// Shared definitions for the bell pulse-train decoder.
// Contents: decoder state enum and the default timing/range constants
// used as parameter defaults by bell_decoder.
package bell_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    HIGH_Q,
    LOW,
    DONE,
    WAIT_LOW
  } bell_state_e;

  localparam int unsigned BELL_GAP_CYCLES = 20_000_000;
  localparam int unsigned BELL_MIN_HIGH   = 1000;
  localparam int unsigned BELL_MAX_COUNT  = 9;
  localparam int unsigned BELL_MIN_PER    = 500_000;
  localparam int unsigned BELL_MAX_PER    = 10_000_000;

endpackage

// File: rtl/bell_sync.sv
// Two-flop synchronizer for the asynchronous bell line.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, clears both flops to 0
//   async_i - asynchronous input
//   sync_o  - synchronized output (2-cycle latency)
module bell_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/bell_decoder.sv
// Bell pulse-train decoder: qualifies pulses on an asynchronous bell line,
// counts the qualified pulses of one burst, measures the spacing of the last
// two pulses and reports both with a one-cycle valid strobe once the line
// has been silent for GAP_CYCLES cycles.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset (discards any burst in progress)
//   bell_in - asynchronous bell line
//   valid   - one-cycle strobe, burst result ready
//   count   - qualified pulses in the burst (saturates at 15)
//   period  - cycles between the last two qualified pulses, 0 if count==1
//   busy    - high while a burst is in progress
//   err     - range violation, meaningful with valid
// Optional feature: define BELL_DEC_RANGE_CHECK_EN to build the range
// checker driving err; otherwise err is tied low.
module bell_decoder
  import bell_pkg::*;
#(
  parameter int unsigned PER_W      = 32,
  parameter int unsigned GAP_CYCLES = BELL_GAP_CYCLES,
  parameter int unsigned MIN_HIGH   = BELL_MIN_HIGH,
  parameter int unsigned MAX_COUNT  = BELL_MAX_COUNT,
  parameter int unsigned MIN_PER    = BELL_MIN_PER,
  parameter int unsigned MAX_PER    = BELL_MAX_PER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bell_in,
  output logic             valid,
  output logic [3:0]       count,
  output logic [PER_W-1:0] period,
  output logic             busy,
  output logic             err
);

  localparam logic [PER_W-1:0] GAP_M1     = PER_W'(GAP_CYCLES - 1);
  localparam logic [PER_W-1:0] MIN_HIGH_L = PER_W'(MIN_HIGH);
  localparam logic [PER_W-1:0] ONE        = PER_W'(1);

  logic s;

  bell_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bell_in),
    .sync_o  (s)
  );

  bell_state_e      state_q, state_d;
  logic [PER_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [PER_W-1:0] since_q, since_d;
  logic [PER_W-1:0] last_per_q, last_per_d;
  logic [3:0]       pulses_q, pulses_d;
  logic [3:0]       count_q;
  logic [PER_W-1:0] period_q;
  logic             err_q, err_d;
  logic             gap_hit;
  logic             qualify;

  assign gap_hit = (since_q >= GAP_M1);

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    since_d    = since_q;
    pulses_d   = pulses_q;
    last_per_d = last_per_q;
    qualify    = 1'b0;

    if ((state_q == HIGH || state_q == HIGH_Q || state_q == LOW) &&
        pulses_q != 4'd0 && since_q != '1) begin
      since_d = since_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d  = HIGH;
          hi_cnt_d = ONE;
        end
      end
      HIGH: begin
        // Gap expiry takes priority over a rising edge that has not yet
        // qualified.
        if (pulses_q != 4'd0 && gap_hit) begin
          state_d = DONE;
        end else if (s) begin
          if (hi_cnt_q + ONE >= MIN_HIGH_L) begin
            qualify = 1'b1;
            state_d = HIGH_Q;
          end else begin
            hi_cnt_d = hi_cnt_q + ONE;
          end
        end else begin
          state_d = (pulses_q == 4'd0) ? IDLE : LOW;
        end
      end
      HIGH_Q: begin
        if (gap_hit)  state_d = DONE;
        else if (!s)  state_d = LOW;
      end
      LOW: begin
        if (gap_hit) begin
          state_d = DONE;
        end else if (s) begin
          state_d  = HIGH;
          hi_cnt_d = ONE;
        end
      end
      DONE: begin
        pulses_d   = 4'd0;
        last_per_d = '0;
        since_d    = '0;
        state_d    = s ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // since_q+1 is the distance between consecutive qualifications, which
    // equals the rising-edge distance since each qualification lags its
    // rise by the same MIN_HIGH cycles.
    if (qualify) begin
      pulses_d = (pulses_q == 4'hF) ? pulses_q : pulses_q + 4'd1;
      if (pulses_q != 4'd0) begin
        last_per_d = (since_q == '1) ? since_q : since_q + ONE;
      end
      since_d = '0;
    end
  end

`ifdef BELL_DEC_RANGE_CHECK_EN
  localparam logic [PER_W-1:0] MIN_PER_L = PER_W'(MIN_PER);
  localparam logic [PER_W-1:0] MAX_PER_L = PER_W'(MAX_PER);

  always_comb begin
    err_d = (32'(pulses_q) > MAX_COUNT) ||
            ((pulses_q >= 4'd2) &&
             ((last_per_q < MIN_PER_L) || (last_per_q > MAX_PER_L)));
  end
`else
  always_comb begin
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_cnt_q   <= '0;
      since_q    <= '0;
      last_per_q <= '0;
      pulses_q   <= 4'd0;
      count_q    <= 4'd0;
      period_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      since_q    <= since_d;
      last_per_q <= last_per_d;
      pulses_q   <= pulses_d;
      // Results are latched on entry to DONE so they are already stable
      // during the valid cycle; pulses/last_per cannot change on that edge.
      if (state_d == DONE) begin
        count_q  <= pulses_q;
        period_q <= (pulses_q == 4'd1) ? '0 : last_per_q;
        err_q    <= err_d;
      end
    end
  end

  assign valid  = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign count  = count_q;
  assign period = period_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bell_decoder.sv
// Scoreboard testbench for bell_decoder: stimulus pushes the expected burst
// result into a queue; a monitor pops and compares on every valid strobe.
module tb_bell_decoder;

  localparam int unsigned PER_W = 16;

`ifdef BELL_DEC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]       c;
    logic [PER_W-1:0] p;
    logic             e;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bell_in = 1'b0;
  logic             valid;
  logic [3:0]       count;
  logic [PER_W-1:0] period;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bell_decoder #(
    .PER_W      (PER_W),
    .GAP_CYCLES (100),
    .MIN_HIGH   (3),
    .MAX_COUNT  (9),
    .MIN_PER    (10),
    .MAX_PER    (40)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bell_in (bell_in),
    .valid   (valid),
    .count   (count),
    .period  (period),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: any valid strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("count", 32'(count), 32'(e.c));
          chk("period", 32'(period), 32'(e.p));
          chk("err", 32'(err), 32'(e.e));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    bell_in = 1'b1;
    cyc(hi);
    bell_in = 1'b0;
    cyc(lo);
  endtask

  task automatic expect_burst(input logic [3:0] c, input logic [PER_W-1:0] p, input logic e);
    exp_t x;
    x.c = c;
    x.p = p;
    x.e = e;
    exp_q.push_back(x);
  endtask

  // Bounded wait for the scoreboard to drain, then the decoder must be idle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    cyc(3);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    cyc(2);
  endtask

  initial begin
    cyc(4);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cyc(3);

    // Three clean pulses at period 20.
    expect_burst(4'd3, 16'd20, 1'b0);
    for (int i = 0; i < 3; i++) pulse(5, 15);
    @(negedge clk);
    chk("busy_in_burst", 32'(busy), 32'd1);
    wait_done("clean3");

    // Single pulse.
    expect_burst(4'd1, 16'd0, 1'b0);
    pulse(8, 10);
    wait_done("single");

    // Period 20 with a 2-cycle glitch in each low phase.
    expect_burst(4'd3, 16'd20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse(5, 6);
      pulse(2, 7);
    end
    wait_done("glitch");

    // Reset mid-burst discards it; the next burst is unaffected.
    pulse(5, 15);
    pulse(5, 15);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_period", 32'(period), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(3);
    expect_burst(4'd2, 16'd20, 1'b0);
    pulse(5, 15);
    pulse(5, 15);
    wait_done("after_rst");

    // Stuck-high line: burst closes while high, then waits for the drop.
    expect_burst(4'd1, 16'd0, 1'b0);
    bell_in = 1'b1;
    cyc(300);
    @(negedge clk);
    chk("stuck_closed_while_high", 32'(exp_q.size()), 32'd0);
    chk("stuck_busy_wait_low", 32'(busy), 32'd1);
    bell_in = 1'b0;
    wait_done("stuck");

    // Ten pulses: count above MAX_COUNT.
    expect_burst(4'd10, 16'd20, RC);
    for (int i = 0; i < 10; i++) pulse(5, 15);
    wait_done("ten");

    // Two pulses with period 50, above MAX_PER.
    expect_burst(4'd2, 16'd50, RC);
    pulse(5, 45);
    pulse(5, 45);
    wait_done("per50");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
